// File: rtl/servant_q_uart_led.sv
// servant_q_uart_led: 8N1 receiver on servant q driving the RGB LED PWM inputs
module servant_q_uart_led #(
  parameter int CLK_FREQ = 16000000,
  parameter int BAUD     = 115200,
  parameter int PWM_BITS = 8,
  parameter int ACT_HOLD = 1600000
) (
  input  logic       wb_clk,
  input  logic       wb_rst,
  input  logic       q,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       pwm_g,
  output logic       pwm_b,
  output logic       pwm_r
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int BW = $clog2(DIV);
  localparam int HW = $clog2(ACT_HOLD + 1);
  localparam logic [BW-1:0] HALF = BW'(DIV / 2 - 1);
  localparam logic [BW-1:0] FULL = BW'(DIV - 1);
  localparam logic [HW-1:0] HOLD = HW'(ACT_HOLD);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state;
  logic q1, qs, qp;
  logic [1:0] flush;
  logic [BW-1:0] bcnt;
  logic [2:0] idx;
  logic [7:0] shreg;
  logic [PWM_BITS-1:0] pcnt, duty_g, duty_b, duty_r;
  logic [HW-1:0] hold_b, hold_r;
  logic fall, tick;
  // edge detect is masked until the reset-high flops have flushed, so a line
  // already low when reset ends never looks like a falling edge
  always_comb begin
    fall = (flush == 2'd3) && qp && !qs;
    tick = bcnt == '0;
    duty_g = PWM_BITS'(rx_data);
    duty_b = hold_b != '0 ? '1 : '0;
    duty_r = hold_r != '0 ? '1 : '0;
  end
  // two-flop synchroniser, previous-value flop and flush counter
  always_ff @(posedge wb_clk)
    if (wb_rst) begin
      {q1, qs, qp} <= 3'b111;
      flush <= 2'd0;
    end else begin
      {q1, qs, qp} <= {q, q1, qs};
      flush <= flush + 2'(flush != 2'd3);
    end
  // receive FSM: mid-bit sampling, LSB-first shift, registered result pulses
  always_ff @(posedge wb_clk)
    if (wb_rst) begin
      state <= IDLE;
      bcnt <= '0;
      idx <= '0;
      shreg <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE:
          if (fall) begin
            bcnt <= HALF;
            state <= START;
          end
        START:
          if (!tick) bcnt <= bcnt - BW'(1);
          else if (qs) state <= IDLE;
          else begin
            bcnt <= FULL;
            idx <= '0;
            state <= DATA;
          end
        DATA:
          if (!tick) bcnt <= bcnt - BW'(1);
          else begin
            shreg <= {qs, shreg[7:1]};
            bcnt <= FULL;
            idx <= idx + 3'd1;
            state <= idx == 3'd7 ? STOP : DATA;
          end
        STOP:
          if (!tick) bcnt <= bcnt - BW'(1);
          else begin
            state <= IDLE;
            if (qs) begin
              rx_data <= shreg;
              rx_valid <= 1'b1;
            end else frame_err <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
  // free-running PWM counter, retriggerable hold timers and registered PWM outputs
  always_ff @(posedge wb_clk)
    if (wb_rst) begin
      pcnt <= '0;
      hold_b <= '0;
      hold_r <= '0;
      {pwm_g, pwm_b, pwm_r} <= 3'b000;
    end else begin
      pcnt <= pcnt + PWM_BITS'(1);
      hold_b <= rx_valid ? HOLD : hold_b - HW'(hold_b != '0);
      hold_r <= frame_err ? HOLD : hold_r - HW'(hold_r != '0);
      pwm_g <= pcnt < duty_g;
      pwm_b <= pcnt < duty_b;
      pwm_r <= pcnt < duty_r;
    end
endmodule

// File: tb/tb_servant_q_uart_led.sv
// tb_servant_q_uart_led: directed tests of the q UART decoder and LED PWM
module tb_servant_q_uart_led;
  logic clk = 1'b0, rst = 1'b1, q = 1'b1;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, pwm_g, pwm_b, pwm_r;
  int checks = 0, errors = 0;
  int cyc = 0, nv = 0, nf = 0, tv = -1000, tv_prev = -1000, rhi = 0, berr = 0;
  logic [7:0] pc = 8'd0, pcp, dv_prev = 8'd0, dv_last = 8'd0;
  logic mon_b = 1'b0;

  servant_q_uart_led #(.CLK_FREQ(1000000), .BAUD(100000), .PWM_BITS(8), .ACT_HOLD(50)) dut (
    .wb_clk(clk), .wb_rst(rst), .q(q), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_err(frame_err), .pwm_g(pwm_g), .pwm_b(pwm_b), .pwm_r(pwm_r));

  always #5 clk = ~clk;

  // reference PWM phase: cleared by reset, +1 per clock; pcp is the phase that set the current pwm outputs
  always @(posedge clk) pc <= rst ? 8'd0 : pc + 8'd1;
  assign pcp = pc - 8'd1;

  // event monitor; blue expected lit for cycles 2..51 after the latest rx_valid, except phase 255
  always @(negedge clk) begin
    cyc++;
    if (pwm_r) rhi++;
    if (mon_b && (pwm_b !== ((cyc - tv >= 2 && cyc - tv <= 51) && pcp != 8'hff))) berr++;
    if (rx_valid) begin
      nv++;
      tv_prev = tv;
      tv = cyc;
      dv_prev = dv_last;
      dv_last = rx_data;
    end
    if (frame_err) nf++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      q = f[i];
      tick(10);
    end
  endtask

  task automatic test_reset;
    tick(3);
    @(negedge clk);
    checks++;
    if ({rx_data, rx_valid, frame_err, pwm_g, pwm_b, pwm_r} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", {rx_data, rx_valid, frame_err, pwm_g, pwm_b, pwm_r});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(10);
  endtask

  task automatic test_basic;
    int v0, f0, h;
    v0 = nv;
    f0 = nf;
    send(8'h55, 1'b1);
    checks++;
    if (cyc - tv !== 1) begin errors++; $display("FAIL basic_latency got %0d want 1", cyc - tv); end
    tick(5);
    checks++;
    if (nv - v0 !== 1) begin errors++; $display("FAIL basic_valid_count got %0d want 1", nv - v0); end
    checks++;
    if (nf - f0 !== 0) begin errors++; $display("FAIL basic_ferr_count got %0d want 0", nf - f0); end
    checks++;
    if (dv_last !== 8'h55) begin errors++; $display("FAIL basic_data_at_valid got %h want 55", dv_last); end
    checks++;
    if (rx_data !== 8'h55) begin errors++; $display("FAIL basic_data_hold got %h want 55", rx_data); end
    h = 0;
    repeat (256) begin
      @(negedge clk);
      if (pwm_g) h++;
    end
    #1;
    checks++;
    if (h !== 85) begin errors++; $display("FAIL basic_pwm_g got %0d want 85", h); end
  endtask

  task automatic test_frame_err;
    int v0, f0, r0;
    for (int i = 0; i < 300 && pc != 8'hff; i++) @(negedge clk);
    @(posedge clk);
    #1;
    v0 = nv;
    f0 = nf;
    r0 = rhi;
    send(8'hA3, 1'b0);
    q = 1'b1;
    tick(200);
    checks++;
    if (nf - f0 !== 1) begin errors++; $display("FAIL ferr_count got %0d want 1", nf - f0); end
    checks++;
    if (nv - v0 !== 0) begin errors++; $display("FAIL ferr_valid_count got %0d want 0", nv - v0); end
    checks++;
    if (rx_data !== 8'h55) begin errors++; $display("FAIL ferr_data_kept got %h want 55", rx_data); end
    checks++;
    if (rhi - r0 !== 50) begin errors++; $display("FAIL ferr_pwm_r_cycles got %0d want 50", rhi - r0); end
    checks++;
    if (pwm_r !== 1'b0) begin errors++; $display("FAIL ferr_pwm_r_off got %b want 0", pwm_r); end
  endtask

  task automatic test_glitch;
    int v0, f0;
    v0 = nv;
    f0 = nf;
    q = 1'b0;
    tick(3);
    q = 1'b1;
    tick(5);
    send(8'h5A, 1'b1);
    tick(5);
    checks++;
    if (nf - f0 !== 0) begin errors++; $display("FAIL glitch_ferr got %0d want 0", nf - f0); end
    checks++;
    if (nv - v0 !== 1) begin errors++; $display("FAIL glitch_valid got %0d want 1", nv - v0); end
    checks++;
    if (rx_data !== 8'h5A) begin errors++; $display("FAIL glitch_next_frame got %h want 5a", rx_data); end
  endtask

  task automatic test_back_to_back;
    int v0, h;
    v0 = nv;
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    tick(5);
    checks++;
    if (nv - v0 !== 2) begin errors++; $display("FAIL b2b_count got %0d want 2", nv - v0); end
    checks++;
    if (tv - tv_prev !== 100) begin errors++; $display("FAIL b2b_spacing got %0d want 100", tv - tv_prev); end
    checks++;
    if (dv_prev !== 8'h00) begin errors++; $display("FAIL b2b_first got %h want 00", dv_prev); end
    checks++;
    if (dv_last !== 8'hFF) begin errors++; $display("FAIL b2b_second got %h want ff", dv_last); end
    h = 0;
    repeat (256) begin
      @(negedge clk);
      if (pwm_g) h++;
    end
    #1;
    checks++;
    if (h !== 255) begin errors++; $display("FAIL b2b_pwm_g got %0d want 255", h); end
  endtask

  task automatic test_reset_mid;
    int v0, f0;
    logic [9:0] f;
    f = {1'b1, 8'h3C, 1'b0};
    v0 = nv;
    f0 = nf;
    for (int i = 0; i < 5; i++) begin
      q = f[i];
      tick(10);
    end
    q = f[5];
    tick(5);
    rst = 1'b1;
    q = 1'b0;
    tick(1);
    @(negedge clk);
    checks++;
    if ({rx_data, rx_valid, frame_err, pwm_g, pwm_b, pwm_r} !== 13'd0) begin
      errors++;
      $display("FAIL rstmid_outputs got %h want 0", {rx_data, rx_valid, frame_err, pwm_g, pwm_b, pwm_r});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(150);
    checks++;
    if (nv - v0 !== 0 || nf - f0 !== 0) begin
      errors++;
      $display("FAIL rstmid_pulses got %0d/%0d want 0/0", nv - v0, nf - f0);
    end
    checks++;
    if ({rx_data, pwm_g, pwm_b, pwm_r} !== 11'd0) begin
      errors++;
      $display("FAIL rstmid_low_line got %h want 0", {rx_data, pwm_g, pwm_b, pwm_r});
    end
    q = 1'b1;
    tick(20);
    send(8'h3C, 1'b1);
    tick(5);
    checks++;
    if (nv - v0 !== 1) begin errors++; $display("FAIL rstmid_restart got %0d want 1", nv - v0); end
    checks++;
    if (rx_data !== 8'h3C) begin errors++; $display("FAIL rstmid_data got %h want 3c", rx_data); end
  endtask

  task automatic test_activity;
    int v0, b0;
    v0 = nv;
    b0 = berr;
    mon_b = 1'b1;
    send(8'h11, 1'b1);
    tick(28);
    send(8'h22, 1'b1);
    tick(60);
    mon_b = 1'b0;
    checks++;
    if (nv - v0 !== 2) begin errors++; $display("FAIL act_count got %0d want 2", nv - v0); end
    checks++;
    if (tv - tv_prev !== 128) begin errors++; $display("FAIL act_spacing got %0d want 128", tv - tv_prev); end
    checks++;
    if (dv_last !== 8'h22) begin errors++; $display("FAIL act_data got %h want 22", dv_last); end
    checks++;
    if (berr - b0 !== 0) begin errors++; $display("FAIL act_pwm_b_window got %0d bad cycles want 0", berr - b0); end
    checks++;
    if (pwm_b !== 1'b0) begin errors++; $display("FAIL act_pwm_b_off got %b want 0", pwm_b); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_frame_err;
    test_glitch;
    test_back_to_back;
    test_reset_mid;
    test_activity;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
